// File: rtl/sig_pkg.sv
// Shared definitions for the signal capture block and the sample generator
// side: default sample/address widths, capture FSM encoding and the mapping
// from FSM state to the one-hot status flags.
package sig_pkg;

    // Default sample width (two's complement) and capture address width.
    localparam int NB_DATA_DEF = 16;
    localparam int NB_ADDR_DEF = 10;

    // Capture FSM states. IDLE is the only state with no status flag raised.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } cap_state_t;

    // Registered status flags presented to the outside world.
    typedef struct packed {
        logic armed;
        logic busy;
        logic done;
    } cap_status_t;

    // One-hot status for a given state; IDLE maps to all-zero.
    function automatic cap_status_t status_of(input cap_state_t state);
        cap_status_t status;
        status = '0;
        case (state)
            ST_ARMED:   status.armed = 1'b1;
            ST_CAPTURE: status.busy  = 1'b1;
            ST_DONE:    status.done  = 1'b1;
            default:    status       = '0;
        endcase
        return status;
    endfunction

endpackage : sig_pkg

// File: rtl/signal_capture_if.sv
// Sample-stream, control, readout and status bundle of the signal capture
// block. Member names are seen from the capture block: i_* flow into it,
// o_* flow out of it. The generator/host side uses the master modport.
interface signal_capture_if #(
    parameter int NB_DATA = sig_pkg::NB_DATA_DEF,
    parameter int NB_ADDR = sig_pkg::NB_ADDR_DEF
);

    // Sample stream and trigger control
    logic [NB_DATA-1:0] i_sample;
    logic               i_valid;
    logic               i_arm;
    logic [NB_DATA-1:0] i_level;

    // Readout port
    logic               i_rd_en;
    logic [NB_ADDR-1:0] i_rd_addr;
    logic [NB_DATA-1:0] o_rd_data;
    logic               o_rd_valid;

    // Status
    logic               o_armed;
    logic               o_busy;
    logic               o_done;

    // Capture block side
    modport slave (
        input  i_sample, i_valid, i_arm, i_level, i_rd_en, i_rd_addr,
        output o_rd_data, o_rd_valid, o_armed, o_busy, o_done
    );

    // Generator / host side
    modport master (
        output i_sample, i_valid, i_arm, i_level, i_rd_en, i_rd_addr,
        input  o_rd_data, o_rd_valid, o_armed, o_busy, o_done
    );

endinterface : signal_capture_if

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one synchronous write port and one
// registered read port, written to map onto a single block RAM. Only the
// read output register is reset; the array itself keeps its contents.
module capture_ram #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] r_mem [DEPTH];
    logic [NB_DATA-1:0] r_rd_data;

    // Write port: store one sample per enabled cycle.
    // NOTE: the array has no reset branch on purpose -- a reset loop over the
    // whole array prevents block RAM inference and the contents must survive
    // reset anyway.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: registered output, cleared by reset, held when not reading.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : capture_ram

// File: rtl/signal_capture.sv
// Triggered signal capture. After an arm pulse the block watches the sample
// stream for a rising crossing of a signed threshold, then stores the
// crossing sample plus the following valid samples until the buffer is full,
// after which the buffer can be read back until the next arm.
module signal_capture
    import sig_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic            i_clock,
    input  logic            i_reset,
    signal_capture_if.slave bus
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};
    localparam logic [NB_ADDR-1:0] FIRST_PTR = NB_ADDR'(1);

    // Registered state
    cap_state_t                r_state;
    logic [NB_ADDR-1:0]        r_wr_ptr;
    logic signed [NB_DATA-1:0] r_prev;
    logic                      r_prev_valid;
    cap_status_t               r_status;
    logic                      r_rd_valid;

    // Combinational datapath
    logic signed [NB_DATA-1:0] w_sample;
    logic signed [NB_DATA-1:0] w_level;
    logic                      w_trigger;
    logic                      w_wr_en;
    logic [NB_ADDR-1:0]        w_wr_addr;
    logic                      w_rd_en;
    logic                      w_last;
    logic [NB_DATA-1:0]        w_rd_data;

    // Signed views of the stream and threshold so the compares are signed.
    assign w_sample = bus.i_sample;
    assign w_level  = bus.i_level;

    // Rising crossing: previous valid sample below the level, current at or
    // above it. Only meaningful while waiting for the trigger.
    assign w_trigger = (r_state == ST_ARMED) && bus.i_valid && r_prev_valid &&
                       (r_prev < w_level) && (w_sample >= w_level);

    // The crossing sample lands at address 0 in the same cycle it is seen;
    // afterwards every valid sample goes to the running write pointer.
    assign w_wr_en   = w_trigger || ((r_state == ST_CAPTURE) && bus.i_valid);
    assign w_wr_addr = (r_state == ST_CAPTURE) ? r_wr_ptr : '0;
    assign w_last    = (r_wr_ptr == LAST_ADDR);

    // Readout is only honoured while the buffer holds a complete capture.
    assign w_rd_en = (r_state == ST_DONE) && bus.i_rd_en;

    capture_ram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_capture_ram (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (bus.i_sample),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (bus.i_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Capture FSM with registered status and read-valid outputs.
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; a blocking = would let later statements
    // see already-updated state and silently change the behaviour.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_status     <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            // Read data appears one cycle after an accepted request.
            r_rd_valid <= w_rd_en;

            case (r_state)
                ST_IDLE: begin
                    if (bus.i_arm) begin
                        r_state      <= ST_ARMED;
                        r_prev_valid <= 1'b0;
                        r_status     <= status_of(ST_ARMED);
                    end
                end

                ST_ARMED: begin
                    if (w_trigger) begin
                        r_state  <= ST_CAPTURE;
                        r_wr_ptr <= FIRST_PTR;
                        r_status <= status_of(ST_CAPTURE);
                    end else if (bus.i_valid) begin
                        r_prev       <= w_sample;
                        r_prev_valid <= 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    if (bus.i_valid) begin
                        // Pointer wraps to 0 naturally after the last address.
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (w_last) begin
                            r_state  <= ST_DONE;
                            r_status <= status_of(ST_DONE);
                        end
                    end
                end

                ST_DONE: begin
                    if (bus.i_arm) begin
                        r_state      <= ST_ARMED;
                        r_prev_valid <= 1'b0;
                        r_status     <= status_of(ST_ARMED);
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_status <= '0;
                end
            endcase
        end
    end

    assign bus.o_rd_data  = w_rd_data;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_armed    = r_status.armed;
    assign bus.o_busy     = r_status.busy;
    assign bus.o_done     = r_status.done;

endmodule : signal_capture
